data_mux_sequencer: RTL and testbench
=====================================

# data_mux_sequencer

Clocked controller that owns the five-slot 2-bit data sequence and steps through it on an internal dwell timer, replacing the hand-driven `nextData` pulse of the existing slot multiplexer. It holds a writable slot table, runs single-shot or looping sequences, and presents the selected slot value with a one-cycle step strobe to downstream display/drive logic.

## Interface
- `DATA_W`, 2, width of each slot value
- `NUM_SLOTS`, 5, number of slots in the sequence (2..8)
- `DWELL_W`, 8, width of the dwell count

- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin sequence at slot 0 (sampled in IDLE or DONE)
- `stop`  in  1  abort the sequence and return to IDLE
- `loopMode`  in  1  1 = wrap after the last slot, 0 = single-shot
- `dwell`  in  DWELL_W  cycles each slot is held; 0 is treated as 1
- `wrEn`  in  1  slot-table write strobe
- `wrAddr`  in  3  slot index to write
- `wrData`  in  DATA_W  slot value to write
- `currentData`  out  DATA_W  registered value of the active slot
- `slotIndex`  out  3  active slot number
- `stepStrobe`  out  1  one-cycle pulse when `slotIndex` advances or wraps
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset (`reset`=0): state IDLE, slot table all 0, `slotIndex`=0, `currentData`=0, `stepStrobe`=0, `busy`=0, `done`=0, dwell counter 0.
- IDLE/DONE + `start`=1 (and `stop`=0) -> RUN, `slotIndex`=0, counter loaded with max(`dwell`,1)-1, `done` cleared.
- RUN, counter != 0: decrement.
- RUN, counter == 0, `slotIndex` < NUM_SLOTS-1: `slotIndex`+1, counter reloaded from current `dwell`, `stepStrobe`=1.
- RUN, counter == 0, last slot: `loopMode`=1 -> `slotIndex`=0, reload, `stepStrobe`=1; `loopMode`=0 -> DONE, `slotIndex` held at NUM_SLOTS-1, no strobe.
- `stop`=1 in any state -> IDLE, `slotIndex`=0. `stop` wins over simultaneous `start` and over a same-cycle step.
- `start` in RUN ignored.
- `dwell` and `loopMode` sampled at each reload only; mid-slot changes take effect at the next step.
- Slot writes accepted in every state; `wrAddr` >= NUM_SLOTS ignored. Write to the active slot reaches `currentData` the cycle after the write edge.
- `currentData` = slot[`slotIndex`], registered; valid in all states (slot 0 in IDLE).

## Timing
- `start` sampled at edge N: `busy`=1, `slotIndex`=0 after edge N.
- Each slot held exactly max(`dwell`,1) cycles; with `dwell`=3, steps at edges N+3, N+6, ...
- `stepStrobe` high in the same cycle the new `slotIndex` is visible; `currentData` follows one cycle later (registered lookup).
- Single-shot: DONE entered max(`dwell`,1) cycles after the last slot appeared; `busy` falls and `done` rises on the same edge.
- Asynchronous reset mid-sequence clears everything immediately; first `start` after deassertion behaves as from IDLE.

## Configuration
- `DATA_MUX_SEQ_PAUSE_EN` defined: adds input `pause` (1 bit). While `pause`=1 in RUN, counter and `slotIndex` freeze, no strobe; `stop` still overrides. Release resumes with the remaining count.
- Undefined: no `pause` port; sequencing never freezes.

## Structure
- Package `data_mux_seq_pkg`: state enum (IDLE, RUN, DONE), default `DATA_W`/`NUM_SLOTS`/`DWELL_W` constants, slot-index width constant.
- One sub-module: `dwell_timer` (load, decrement, zero flag, optional freeze). FSM, slot table and output registers stay in the top.

## Test plan
- Reset with slots written 10,11,00,01,00, `dwell`=2, `loopMode`=0, `start` pulse -> `currentData` sequence 10,11,00,01,00 each 2 cycles, 4 strobes, `done`=1, `slotIndex`=4.
- `loopMode`=1, `dwell`=1 -> strobe every cycle, `slotIndex` 0..4,0,1..., `done` never set.
- `dwell`=0 -> identical to `dwell`=1 timing.
- `stop` and `start` in same cycle during RUN at slot 3 -> IDLE, `slotIndex`=0, `busy`=0.
- Write slot 2 = 11 while slot 2 active, plus `wrAddr`=6 -> `currentData`=11 next cycle; slot table otherwise unchanged.
- `reset` asserted mid-dwell at slot 2 -> all outputs and slot table 0 immediately; with `DATA_MUX_SEQ_PAUSE_EN`, `pause` for 5 cycles extends that slot by exactly 5 cycles.

Source files
------------

// File: rtl/data_mux_seq_pkg.sv
// Shared types and default sizing for the data_mux_sequencer slice.
// Optional pause support is controlled by DATA_MUX_SEQ_PAUSE_EN in the top.
package data_mux_seq_pkg;

  localparam int DATA_W_DEF    = 2;
  localparam int NUM_SLOTS_DEF = 5;
  localparam int DWELL_W_DEF   = 8;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/data_mux_sequencer_dwell_timer.sv
// Dwell down-counter: load wins, otherwise decrements toward zero unless frozen.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         freeze_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!freeze_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/data_mux_sequencer.sv
// Slot-table sequencer: steps a 5-slot data table on an internal dwell timer.
// Define DATA_MUX_SEQ_PAUSE_EN to add the 'pause' input that freezes a running sequence.
module data_mux_sequencer
  import data_mux_seq_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int DWELL_W   = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loopMode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               wrEn,
  input  logic [IDX_W-1:0]   wrAddr,
  input  logic [DATA_W-1:0]  wrData,
`ifdef DATA_MUX_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic [DATA_W-1:0]  currentData,
  output logic [IDX_W-1:0]   slotIndex,
  output logic               stepStrobe,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              strobe_q, strobe_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] slot_q [NUM_SLOTS];

  logic               pause_w;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [DWELL_W-1:0] reload_val;

`ifdef DATA_MUX_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // A dwell of 0 holds a slot for one cycle, same as a dwell of 1.
  assign reload_val = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst_n_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .freeze_i   (pause_w || (state_q != RUN)),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    loop_d   = loop_q;
    tmr_load = 1'b0;
    tmr_val  = reload_val;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          idx_d    = '0;
          tmr_load = 1'b1;
          loop_d   = loopMode;
        end
      end
      RUN: begin
        if (!pause_w && tmr_zero) begin
          if (idx_q < LAST_IDX) begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            loop_d   = loopMode;
            strobe_d = 1'b1;
          end else if (loop_q) begin
            idx_d    = '0;
            tmr_load = 1'b1;
            loop_d   = loopMode;
            strobe_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides start and any step decided above.
    if (stop) begin
      state_d  = IDLE;
      idx_d    = '0;
      strobe_d = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      loop_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      loop_q   <= loop_d;
      data_q   <= slot_q[idx_q];
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [DATA_W-1:0] val_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
      end else if (wrEn && (wrAddr == IDX_W'(gi))) begin
        val_q <= wrData;
      end
    end
    assign slot_q[gi] = val_q;
  end

  assign currentData = data_q;
  assign slotIndex   = idx_q;
  assign stepStrobe  = strobe_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_data_mux_sequencer.sv
// Self-checking bench for data_mux_sequencer against a slot-schedule model.
// Build with DATA_MUX_SEQ_PAUSE_EN to also exercise the pause feature.
module tb_data_mux_sequencer;

  localparam int DW = 2;
  localparam int NS = 5;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loopMode = 1'b0;
  logic [WW-1:0] dwell = '0;
  logic          wrEn = 1'b0;
  logic [2:0]    wrAddr = '0;
  logic [DW-1:0] wrData = '0;
`ifdef DATA_MUX_SEQ_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic [DW-1:0] currentData;
  logic [2:0]    slotIndex;
  logic          stepStrobe;
  logic          busy;
  logic          done;

  data_mux_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loopMode    (loopMode),
    .dwell       (dwell),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
`ifdef DATA_MUX_SEQ_PAUSE_EN
    .pause       (pause),
`endif
    .currentData (currentData),
    .slotIndex   (slotIndex),
    .stepStrobe  (stepStrobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: slot table, hold length, loop flag, elapsed run cycles, expected index.
  logic [DW-1:0] tbl [NS];
  int D = 1;
  bit lp = 1'b0;
  int keff = 0;
  int exp_idx = 0;
  int strobe_seen = 0;

  function automatic int idx_at(input int k);
    int s;
    s = k / D;
    if (lp) return s % NS;
    return (s >= NS) ? NS - 1 : s;
  endfunction

  function automatic bit busy_at(input int k);
    return lp || (k < NS * D);
  endfunction

  function automatic bit strobe_at(input int k);
    return (k > 0) && ((k % D) == 0) && busy_at(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_idx, input bit e_s,
                           input bit e_b, input bit e_d, input logic [DW-1:0] e_data);
    check({tag, "_idx"},    32'(slotIndex),   32'(e_idx));
    check({tag, "_strobe"}, 32'(stepStrobe),  32'(e_s));
    check({tag, "_busy"},   32'(busy),        32'(e_b));
    check({tag, "_done"},   32'(done),        32'(e_d));
    check({tag, "_data"},   32'(currentData), 32'(e_data));
    $display("[%0t] %s k=%0d idx=%0d strobe=%0b busy=%0b done=%0b data=%0d",
             $time, tag, keff, slotIndex, stepStrobe, busy, done, currentData);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int a, input int v);
    wrEn = 1'b1;
    wrAddr = 3'(a);
    wrData = DW'(v);
    tick();
    wrEn = 1'b0;
    if (a < NS) tbl[a] = DW'(v);
  endtask

  task automatic start_run(input int d, input bit l, input string tag);
    int prev;
    dwell = WW'(d);
    loopMode = l;
    D = (d == 0) ? 1 : d;
    lp = l;
    prev = exp_idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    keff = 0;
    exp_idx = 0;
    strobe_seen = 0;
    check_all(tag, 0, 1'b0, 1'b1, 1'b0, tbl[prev]);
  endtask

  task automatic run(input int n, input int pause_at, input int pause_len,
                     input int start_at, input string tag);
    for (int i = 0; i < n; i++) begin
      bit frz;
      int prev;
      frz = (pause_at >= 0) && (i >= pause_at) && (i < pause_at + pause_len);
`ifdef DATA_MUX_SEQ_PAUSE_EN
      pause = frz;
`endif
      start = (i == start_at);
      prev = exp_idx;
      tick();
      if (!frz) keff++;
      exp_idx = idx_at(keff);
      check_all(tag, exp_idx, !frz && strobe_at(keff), busy_at(keff), !busy_at(keff), tbl[prev]);
      if (stepStrobe) strobe_seen++;
    end
    start = 1'b0;
`ifdef DATA_MUX_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  task automatic do_stop(input bit with_start, input string tag);
    int prev;
    prev = exp_idx;
    stop = 1'b1;
    start = with_start;
    tick();
    stop = 1'b0;
    start = 1'b0;
    exp_idx = 0;
    check_all(tag, 0, 1'b0, 1'b0, 1'b0, tbl[prev]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) tbl[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;

    // Single-shot, dwell 2, table 10,11,00,01,00
    write_slot(0, 2); write_slot(1, 3); write_slot(2, 0); write_slot(3, 1); write_slot(4, 0);
    start_run(2, 1'b0, "single");
    run(12, -1, 0, -1, "single");
    check("single_strobes", 32'(strobe_seen), 32'd4);

    // Restart directly from DONE, then stop+start together at slot 3
    start_run(2, 1'b0, "restart");
    run(6, -1, 0, -1, "restart");
    check("at_slot3", 32'(slotIndex), 32'd3);
    do_stop(1'b1, "stop_start");

    // Loop, dwell 1; a start mid-run is ignored
    start_run(1, 1'b1, "loop1");
    run(13, -1, 0, 5, "loop1");
    do_stop(1'b0, "loop1_stop");

    // Dwell 0 behaves as dwell 1
    start_run(0, 1'b1, "loop0");
    run(12, -1, 0, -1, "loop0");
    do_stop(1'b0, "loop0_stop");
    start_run(0, 1'b0, "single0");
    run(7, -1, 0, -1, "single0");

    // Write active slot 2, then an out-of-range address
    start_run(6, 1'b0, "wr");
    run(13, -1, 0, -1, "wr");
    wrEn = 1'b1; wrAddr = 3'd2; wrData = 2'b11;
    tick();
    keff++;
    check("wr_old_data", 32'(currentData), 32'(tbl[2]));
    tbl[2] = 2'b11;
    wrAddr = 3'd6; wrData = 2'b01;
    tick();
    keff++;
    wrEn = 1'b0;
    check("wr_new_data", 32'(currentData), 32'd3);
    exp_idx = idx_at(keff);
    run(20, -1, 0, -1, "wr_tail");
    start_run(1, 1'b0, "wr_verify");
    run(7, -1, 0, -1, "wr_verify");
    do_stop(1'b0, "wr_verify_stop");

    // Randomized runs
    for (int it = 0; it < 6; it++) begin
      int d;
      bit l;
      for (int s = 0; s < NS; s++) write_slot(s, int'($urandom_range(0, 3)));
      d = int'($urandom_range(0, 3));
      l = 1'($urandom_range(0, 1));
      start_run(d, l, "rand");
      run(l ? 17 : NS * ((d == 0) ? 1 : d) + 2, -1, 0, -1, "rand");
      if (l || ($urandom_range(0, 1) == 1)) do_stop(1'b0, "rand_stop");
    end
    if (exp_idx != 0) do_stop(1'b0, "rand_stop");

`ifdef DATA_MUX_SEQ_PAUSE_EN
    // Pause at slot 2 for 5 cycles stretches that slot by 5
    start_run(2, 1'b0, "pause");
    run(4, -1, 0, -1, "pause");
    run(18, 1, 5, -1, "pause");
    check("pause_done", 32'(done), 32'd1);
    do_stop(1'b0, "pause_stop");
`endif

    // Asynchronous reset mid-dwell at slot 2
    start_run(3, 1'b0, "arst");
    run(7, -1, 0, -1, "arst");
    #2 reset = 1'b0;
    #1;
    check_all("arst_now", 0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < NS; i++) tbl[i] = '0;
    exp_idx = 0;
    start_run(2, 1'b0, "post_rst");
    run(12, -1, 0, -1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
